// File: rtl/execute_stage.sv
// Three-pipe execute stage: operand forwarding from the previous bundle, ALU,
// and a registered handoff to writeback with flush and async active-low reset.
module execute_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic [3:0]  d2e_instpipe1,
  input  logic [3:0]  d2e_instpipe2,
  input  logic [3:0]  d2e_instpipe3,
  input  logic [3:0]  d2e_destpipe1,
  input  logic [3:0]  d2e_destpipe2,
  input  logic [3:0]  d2e_destpipe3,
  input  logic [63:0] d2e_immpipe1,
  input  logic [63:0] d2e_immpipe2,
  input  logic [63:0] d2e_immpipe3,
  input  logic [63:0] r2e_src1datapipe1,
  input  logic [63:0] r2e_src1datapipe2,
  input  logic [63:0] r2e_src1datapipe3,
  input  logic [63:0] r2e_src2datapipe1,
  input  logic [63:0] r2e_src2datapipe2,
  input  logic [63:0] r2e_src2datapipe3,
  input  logic [3:0]  r2e_src1pipe1,
  input  logic [3:0]  r2e_src1pipe2,
  input  logic [3:0]  r2e_src1pipe3,
  input  logic [3:0]  r2e_src2pipe1,
  input  logic [3:0]  r2e_src2pipe2,
  input  logic [3:0]  r2e_src2pipe3,
  output logic [63:0] e2w_datapipe1,
  output logic [63:0] e2w_datapipe2,
  output logic [63:0] e2w_datapipe3,
  output logic [3:0]  e2w_destpipe1,
  output logic [3:0]  e2w_destpipe2,
  output logic [3:0]  e2w_destpipe3,
  output logic        e2w_wrpipe1,
  output logic        e2w_wrpipe2,
  output logic        e2w_wrpipe3,
  output logic        e2w_rdvalidpipe1,
  output logic        e2w_rdvalidpipe2,
  output logic        e2w_rdvalidpipe3
);

  localparam int unsigned DW = 64;
  localparam int unsigned RW = 4;
  localparam int unsigned OW = 4;
  localparam int unsigned NP = 3;

  localparam logic [OW-1:0] OP_NOP  = 4'h0;
  localparam logic [OW-1:0] OP_MUL  = 4'h3;
  localparam logic [OW-1:0] OP_LOAD = 4'h4;
  localparam logic [OW-1:0] OP_READ = 4'h6;

  logic [OW-1:0] inst     [NP];
  logic [RW-1:0] dest     [NP];
  logic [DW-1:0] imm      [NP];
  logic [DW-1:0] src1data [NP];
  logic [DW-1:0] src2data [NP];
  logic [RW-1:0] src1     [NP];
  logic [RW-1:0] src2     [NP];

  logic [DW-1:0] a_eff  [NP];
  logic [DW-1:0] b_eff  [NP];
  logic [DW-1:0] result [NP];

  logic [DW-1:0] data_q [NP];
  logic [RW-1:0] dest_q [NP];
  logic          wr_q   [NP];
  logic          rdv_q  [NP];

  assign inst[0] = d2e_instpipe1;      assign inst[1] = d2e_instpipe2;      assign inst[2] = d2e_instpipe3;
  assign dest[0] = d2e_destpipe1;      assign dest[1] = d2e_destpipe2;      assign dest[2] = d2e_destpipe3;
  assign imm[0]  = d2e_immpipe1;       assign imm[1]  = d2e_immpipe2;       assign imm[2]  = d2e_immpipe3;
  assign src1data[0] = r2e_src1datapipe1;
  assign src1data[1] = r2e_src1datapipe2;
  assign src1data[2] = r2e_src1datapipe3;
  assign src2data[0] = r2e_src2datapipe1;
  assign src2data[1] = r2e_src2datapipe2;
  assign src2data[2] = r2e_src2datapipe3;
  assign src1[0] = r2e_src1pipe1;      assign src1[1] = r2e_src1pipe2;      assign src1[2] = r2e_src1pipe3;
  assign src2[0] = r2e_src2pipe1;      assign src2[1] = r2e_src2pipe2;      assign src2[2] = r2e_src2pipe3;

  function automatic logic uses_src1(input logic [OW-1:0] op);
    return !(op == OP_NOP || op == OP_LOAD);
  endfunction

  function automatic logic uses_src2(input logic [OW-1:0] op);
    return (op >= 4'h1 && op <= 4'h3) || (op >= 4'h7 && op <= 4'hA) || (op >= 4'hC);
  endfunction

  // Shift/rotate amount is always B[3:0]; a zero rotate relies on a>>64 == 0.
  function automatic logic [DW-1:0] alu(input logic [OW-1:0] op,
                                        input logic [DW-1:0] a,
                                        input logic [DW-1:0] b,
                                        input logic [DW-1:0] im);
    logic [3:0] sh;
    logic [6:0] inv;
    sh  = b[3:0];
    inv = 7'd64 - 7'(sh);
    case (op)
      4'h1:    return a + b;
      4'h2:    return a - b;
      4'h3:    return 64'(a[31:0]) * 64'(b[31:0]);
      4'h4:    return im;
      4'h5:    return a;
      4'h6:    return a;
      4'h7:    return (a == b) ? 64'd1 : ((a > b) ? 64'd2 : 64'd0);
      4'h8:    return a ^ b;
      4'h9:    return ~(a & b);
      4'hA:    return ~(a | b);
      4'hB:    return ~a;
      4'hC:    return a << sh;
      4'hD:    return a >> sh;
      4'hE:    return (a << sh) | (a >> inv);
      4'hF:    return (a >> sh) | (a << inv);
      default: return '0;
    endcase
  endfunction

  // Forward from the previous bundle; ascending scan lets pipe 3 win over 2 over 1.
  always_comb begin
    for (int p = 0; p < int'(NP); p++) begin
      a_eff[p]  = src1data[p];
      b_eff[p]  = src2data[p];
      result[p] = '0;
      for (int m = 0; m < int'(NP); m++) begin
        if (uses_src1(inst[p]) && wr_q[m] && dest_q[m] == src1[p]) a_eff[p] = data_q[m];
        if (uses_src2(inst[p]) && wr_q[m] && dest_q[m] == src2[p]) b_eff[p] = data_q[m];
      end
      if (inst[p] == OP_MUL) begin
        a_eff[p] = {32'd0, a_eff[p][31:0]};
        b_eff[p] = {32'd0, b_eff[p][31:0]};
      end
      if (inst[p][3:2] == 2'b11) b_eff[p] = {60'd0, b_eff[p][3:0]};
      result[p] = alu(inst[p], a_eff[p], b_eff[p], imm[p]);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int p = 0; p < int'(NP); p++) begin
        data_q[p] <= '0;
        dest_q[p] <= '0;
        wr_q[p]   <= 1'b0;
        rdv_q[p]  <= 1'b0;
      end
    end else if (flush) begin
      for (int p = 0; p < int'(NP); p++) begin
        data_q[p] <= '0;
        dest_q[p] <= '0;
        wr_q[p]   <= 1'b0;
        rdv_q[p]  <= 1'b0;
      end
    end else begin
      for (int p = 0; p < int'(NP); p++) begin
        data_q[p] <= result[p];
        dest_q[p] <= dest[p];
        wr_q[p]   <= (inst[p] != OP_NOP) && (inst[p] != OP_READ);
        rdv_q[p]  <= (inst[p] == OP_READ);
      end
    end
  end

  assign e2w_datapipe1    = data_q[0];
  assign e2w_datapipe2    = data_q[1];
  assign e2w_datapipe3    = data_q[2];
  assign e2w_destpipe1    = dest_q[0];
  assign e2w_destpipe2    = dest_q[1];
  assign e2w_destpipe3    = dest_q[2];
  assign e2w_wrpipe1      = wr_q[0];
  assign e2w_wrpipe2      = wr_q[1];
  assign e2w_wrpipe3      = wr_q[2];
  assign e2w_rdvalidpipe1 = rdv_q[0];
  assign e2w_rdvalidpipe2 = rdv_q[1];
  assign e2w_rdvalidpipe3 = rdv_q[2];

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: ALU ops, forwarding priority, flush and async reset.
module tb_execute_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic [3:0]  inst1, inst2, inst3, dst1, dst2, dst3;
  logic [63:0] imm1, imm2, imm3;
  logic [63:0] a1, a2, a3, b1, b2, b3;
  logic [3:0]  s1_1, s1_2, s1_3, s2_1, s2_2, s2_3;
  logic [63:0] data1, data2, data3;
  logic [3:0]  dest1, dest2, dest3;
  logic        wr1, wr2, wr3, rdv1, rdv2, rdv3;

  int compared = 0;
  int mismatched = 0;

  always #5 clock = ~clock;

  execute_stage dut (
    .clock(clock), .reset(reset), .flush(flush),
    .d2e_instpipe1(inst1), .d2e_instpipe2(inst2), .d2e_instpipe3(inst3),
    .d2e_destpipe1(dst1), .d2e_destpipe2(dst2), .d2e_destpipe3(dst3),
    .d2e_immpipe1(imm1), .d2e_immpipe2(imm2), .d2e_immpipe3(imm3),
    .r2e_src1datapipe1(a1), .r2e_src1datapipe2(a2), .r2e_src1datapipe3(a3),
    .r2e_src2datapipe1(b1), .r2e_src2datapipe2(b2), .r2e_src2datapipe3(b3),
    .r2e_src1pipe1(s1_1), .r2e_src1pipe2(s1_2), .r2e_src1pipe3(s1_3),
    .r2e_src2pipe1(s2_1), .r2e_src2pipe2(s2_2), .r2e_src2pipe3(s2_3),
    .e2w_datapipe1(data1), .e2w_datapipe2(data2), .e2w_datapipe3(data3),
    .e2w_destpipe1(dest1), .e2w_destpipe2(dest2), .e2w_destpipe3(dest3),
    .e2w_wrpipe1(wr1), .e2w_wrpipe2(wr2), .e2w_wrpipe3(wr3),
    .e2w_rdvalidpipe1(rdv1), .e2w_rdvalidpipe2(rdv2), .e2w_rdvalidpipe3(rdv3)
  );

  // Sources 10..12 are never used as a destination, so they never forward.
  task automatic clear_inputs();
    flush = 1'b0;
    inst1 = 4'h0; inst2 = 4'h0; inst3 = 4'h0;
    dst1 = 4'd0; dst2 = 4'd0; dst3 = 4'd0;
    imm1 = '0; imm2 = '0; imm3 = '0;
    a1 = '0; a2 = '0; a3 = '0; b1 = '0; b2 = '0; b3 = '0;
    s1_1 = 4'd10; s1_2 = 4'd10; s1_3 = 4'd10;
    s2_1 = 4'd11; s2_2 = 4'd11; s2_3 = 4'd11;
  endtask

  task automatic set_pipe(input int p, input logic [3:0] op, input logic [3:0] d,
                          input logic [3:0] s1, input logic [63:0] a,
                          input logic [3:0] s2, input logic [63:0] b,
                          input logic [63:0] im);
    case (p)
      1: begin inst1 = op; dst1 = d; s1_1 = s1; a1 = a; s2_1 = s2; b1 = b; imm1 = im; end
      2: begin inst2 = op; dst2 = d; s1_2 = s1; a2 = a; s2_2 = s2; b2 = b; imm2 = im; end
      default: begin inst3 = op; dst3 = d; s1_3 = s1; a3 = a; s2_3 = s2; b3 = b; imm3 = im; end
    endcase
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clear_inputs();
    set_pipe(1, 4'h1, 4'd3, 4'd10, 64'd5, 4'd11, 64'd7, 64'd0);
    #2;
    compared++;
    if (data1 !== 64'd0 || wr1 !== 1'b0 || dest1 !== 4'd0 || rdv1 !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_p1: data=%h wr=%b dest=%0d rdv=%b expected all 0", data1, wr1, dest1, rdv1);
    end
    compared++;
    if (data3 !== 64'd0 || wr2 !== 1'b0 || wr3 !== 1'b0 || dest3 !== 4'd0) begin
      mismatched++;
      $display("FAIL reset_p23: data3=%h wr2=%b wr3=%b dest3=%0d expected all 0", data3, wr2, wr3, dest3);
    end
    @(negedge clock);
    reset = 1'b1;
    clear_inputs();
    tick();
  endtask

  task automatic test_add_forward();
    clear_inputs();
    set_pipe(1, 4'h1, 4'd3, 4'd10, 64'd5, 4'd11, 64'd7, 64'd0);
    tick();
    compared++;
    if (data1 !== 64'd12 || wr1 !== 1'b1 || dest1 !== 4'd3) begin
      mismatched++;
      $display("FAIL add: data=%0d wr=%b dest=%0d expected 12/1/3", data1, wr1, dest1);
    end
    clear_inputs();
    set_pipe(2, 4'h1, 4'd5, 4'd3, 64'd0, 4'd12, 64'd1, 64'd0);
    tick();
    compared++;
    if (data2 !== 64'd13 || wr1 !== 1'b0) begin
      mismatched++;
      $display("FAIL add_fwd: data2=%0d wr1=%b expected 13/0", data2, wr1);
    end
  endtask

  task automatic test_priority();
    clear_inputs();
    set_pipe(1, 4'h4, 4'd4, 4'd10, 64'd0, 4'd11, 64'd0, 64'd10);
    set_pipe(3, 4'h4, 4'd4, 4'd10, 64'd0, 4'd11, 64'd0, 64'd30);
    tick();
    compared++;
    if (data1 !== 64'd10 || data3 !== 64'd30 || dest1 !== 4'd4 || dest3 !== 4'd4 || wr3 !== 1'b1) begin
      mismatched++;
      $display("FAIL same_dest: d1=%0d d3=%0d dest1=%0d dest3=%0d wr3=%b expected 10/30/4/4/1",
               data1, data3, dest1, dest3, wr3);
    end
    clear_inputs();
    set_pipe(1, 4'h5, 4'd6, 4'd4, 64'd0, 4'd11, 64'd0, 64'd0);
    tick();
    compared++;
    if (data1 !== 64'd30) begin
      mismatched++;
      $display("FAIL priority: data1=%0d expected 30", data1);
    end
  endtask

  task automatic test_mul_shift();
    clear_inputs();
    set_pipe(1, 4'h3, 4'd1, 4'd10, 64'h1_0000_0002, 4'd11, 64'd3, 64'd0);
    set_pipe(2, 4'hF, 4'd7, 4'd10, 64'h1, 4'd11, 64'h21, 64'd0);
    set_pipe(3, 4'h4, 4'd8, 4'd10, 64'd0, 4'd11, 64'd0, 64'hFFFF_0000_0000_0005);
    tick();
    compared++;
    if (data1 !== 64'd6) begin
      mismatched++;
      $display("FAIL mul: data1=%h expected 6", data1);
    end
    compared++;
    if (data2 !== 64'h8000_0000_0000_0000) begin
      mismatched++;
      $display("FAIL rotr: data2=%h expected 8000000000000000", data2);
    end
    clear_inputs();
    set_pipe(1, 4'hC, 4'd1, 4'd10, 64'd1, 4'd12, 64'd0, 64'd0);
    set_pipe(2, 4'h3, 4'd2, 4'd8, 64'd0, 4'd11, 64'd3, 64'd0);
    set_pipe(3, 4'hE, 4'd3, 4'd10, 64'h8000_0000_0000_0001, 4'd12, 64'd1, 64'd0);
    tick();
    compared++;
    if (data1 !== 64'd1) begin
      mismatched++;
      $display("FAIL shl0: data1=%h expected 1", data1);
    end
    compared++;
    if (data2 !== 64'd15) begin
      mismatched++;
      $display("FAIL mul_fwd_mask: data2=%h expected f", data2);
    end
    compared++;
    if (data3 !== 64'd3) begin
      mismatched++;
      $display("FAIL rotl: data3=%h expected 3", data3);
    end
  endtask

  task automatic test_logic();
    clear_inputs();
    set_pipe(1, 4'h2, 4'd1, 4'd10, 64'd5, 4'd11, 64'd7, 64'd0);
    set_pipe(2, 4'h9, 4'd2, 4'd10, 64'hF0, 4'd11, 64'h3C, 64'd0);
    set_pipe(3, 4'hD, 4'd3, 4'd10, 64'h100, 4'd11, 64'd4, 64'd0);
    tick();
    compared++;
    if (data1 !== 64'hFFFF_FFFF_FFFF_FFFE || data2 !== 64'hFFFF_FFFF_FFFF_FFCF || data3 !== 64'h10) begin
      mismatched++;
      $display("FAIL sub_nand_shr: %h %h %h expected fffffffffffffffe ffffffffffffffcf 10",
               data1, data2, data3);
    end
    clear_inputs();
    set_pipe(1, 4'h8, 4'd1, 4'd10, 64'hFF00, 4'd11, 64'h0FF0, 64'd0);
    set_pipe(2, 4'hA, 4'd2, 4'd10, 64'h1, 4'd11, 64'h2, 64'd0);
    set_pipe(3, 4'hB, 4'd3, 4'd10, 64'h0, 4'd11, 64'h5, 64'd0);
    tick();
    compared++;
    if (data1 !== 64'hF0F0 || data2 !== 64'hFFFF_FFFF_FFFF_FFFC || data3 !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      mismatched++;
      $display("FAIL xor_nor_not: %h %h %h expected f0f0 fffffffffffffffc ffffffffffffffff",
               data1, data2, data3);
    end
  endtask

  task automatic test_compare_read();
    clear_inputs();
    set_pipe(1, 4'h7, 4'd1, 4'd10, 64'd5, 4'd11, 64'd5, 64'd0);
    set_pipe(2, 4'h7, 4'd2, 4'd10, 64'd9, 4'd11, 64'd4, 64'd0);
    set_pipe(3, 4'h7, 4'd3, 4'd10, 64'd4, 4'd11, 64'd9, 64'd0);
    tick();
    compared++;
    if (data1 !== 64'd1 || data2 !== 64'd2 || data3 !== 64'd0 || wr3 !== 1'b1) begin
      mismatched++;
      $display("FAIL compare: %0d %0d %0d wr3=%b expected 1 2 0 1", data1, data2, data3, wr3);
    end
    clear_inputs();
    set_pipe(1, 4'h6, 4'd9, 4'd10, 64'hABC, 4'd11, 64'd0, 64'd0);
    tick();
    compared++;
    if (data1 !== 64'hABC || wr1 !== 1'b0 || rdv1 !== 1'b1 || rdv2 !== 1'b0) begin
      mismatched++;
      $display("FAIL read: data=%h wr=%b rdv=%b rdv2=%b expected abc/0/1/0", data1, wr1, rdv1, rdv2);
    end
  endtask

  task automatic test_back_to_back();
    clear_inputs();
    set_pipe(1, 4'h4, 4'd5, 4'd10, 64'd0, 4'd11, 64'd0, 64'd99);
    set_pipe(2, 4'h5, 4'd6, 4'd5, 64'd7, 4'd11, 64'd0, 64'd0);
    tick();
    compared++;
    if (data1 !== 64'd99 || data2 !== 64'd7) begin
      mismatched++;
      $display("FAIL intra_bundle: d1=%0d d2=%0d expected 99/7", data1, data2);
    end
  endtask

  task automatic test_flush();
    clear_inputs();
    set_pipe(1, 4'h1, 4'd2, 4'd10, 64'd1, 4'd11, 64'd1, 64'd0);
    flush = 1'b1;
    tick();
    compared++;
    if (data1 !== 64'd0 || wr1 !== 1'b0 || dest1 !== 4'd0 || data2 !== 64'd0 || dest2 !== 4'd0) begin
      mismatched++;
      $display("FAIL flush: data1=%h wr1=%b dest1=%0d data2=%h dest2=%0d expected 0",
               data1, wr1, dest1, data2, dest2);
    end
    clear_inputs();
    set_pipe(1, 4'h5, 4'd7, 4'd2, 64'h55, 4'd11, 64'd0, 64'd0);
    set_pipe(2, 4'h5, 4'd8, 4'd5, 64'h66, 4'd11, 64'd0, 64'd0);
    tick();
    compared++;
    if (data1 !== 64'h55 || data2 !== 64'h66 || dest1 !== 4'd7) begin
      mismatched++;
      $display("FAIL post_flush: d1=%h d2=%h dest1=%0d expected 55/66/7", data1, data2, dest1);
    end
  endtask

  task automatic test_async_reset();
    clear_inputs();
    set_pipe(1, 4'h4, 4'd3, 4'd10, 64'd0, 4'd11, 64'd0, 64'h77);
    tick();
    compared++;
    if (data1 !== 64'h77 || wr1 !== 1'b1) begin
      mismatched++;
      $display("FAIL pre_reset: data1=%h wr1=%b expected 77/1", data1, wr1);
    end
    #2;
    reset = 1'b0;
    #1;
    compared++;
    if (data1 !== 64'd0 || wr1 !== 1'b0 || dest1 !== 4'd0) begin
      mismatched++;
      $display("FAIL async_reset: data1=%h wr1=%b dest1=%0d expected 0", data1, wr1, dest1);
    end
    clear_inputs();
    set_pipe(1, 4'h5, 4'd4, 4'd3, 64'h11, 4'd11, 64'd0, 64'd0);
    #2;
    reset = 1'b1;
    tick();
    compared++;
    if (data1 !== 64'h11) begin
      mismatched++;
      $display("FAIL post_reset_fwd: data1=%h expected 11", data1);
    end
  endtask

  initial begin
    test_reset();
    test_add_forward();
    test_priority();
    test_mul_shift();
    test_logic();
    test_compare_read();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 64, register index width at 4, opcode width at 4, and there are 3 pipes (N = 1, 2, 3).
REQ-002 The block SHALL have these ports, clock and reset first:
- clock  in  1  rising-edge clock.
- reset  in  1  one clock; reset is asynchronous and active-low.
- flush  in  1  synchronous squash of the instructions currently at the inputs.
- d2e_instpipeN  in  4  opcode, aligned with the operand data.
- d2e_destpipeN  in  4  destination register index.
- d2e_immpipeN  in  64  immediate value, used by load only.
- r2e_src1datapipeN, r2e_src2datapipeN  in  64  operand data from the register-file stage, already masked per opcode.
- r2e_src1pipeN, r2e_src2pipeN  in  4  operand register indices.
- e2w_datapipeN  out  64  registered result.
- e2w_destpipeN  out  4  registered destination index.
- e2w_wrpipeN  out  1  registered register-write enable.
- e2w_rdvalidpipeN  out  1  registered read-port valid.

Function
REQ-003 All outputs SHALL be registered, with a latency of exactly 1 clock from the inputs to e2w_*; there is no stall and no backpressure.
REQ-004 Opcode results, with all arithmetic modulo 2^64 and A/B the effective operands (REQ-008):
- 0000 nop: result 0, wr 0.
- 0001 add: A+B.
- 0010 sub: A-B.
- 0011 mul: A[31:0]*B[31:0], full 64-bit product.
- 0100 load: d2e_immpipeN.
- 0101 move: A.
- 0111 compare: 1 if A==B, 2 if A>B unsigned, 0 if A<B.
- 1000 xor: A^B.
- 1001 nand: ~(A&B).
- 1010 nor: ~(A|B).
- 1011 not: ~A.
REQ-005 Shift opcodes SHALL use B[3:0] as the shift amount (0..15):
- 1100: logical left.
- 1101: logical right.
- 1110: rotate left.
- 1111: rotate right.
A shift amount of 0 SHALL pass A unchanged.
REQ-006 e2w_wrpipeN SHALL be 1 for every opcode except 0000 and 0110.
REQ-007 Opcode 0110 (read) SHALL drive e2w_datapipeN=A, e2w_wrpipeN=0, and e2w_rdvalidpipeN=1; e2w_rdvalidpipeN SHALL be 0 for all other opcodes.
REQ-008 Forwarding: the effective operand SHALL be taken from a previous result instead of r2e data when all of the following hold:
- the opcode uses that source (src1: all except 0000/0100; src2: 0001-0011, 0111-1010, 1100-1111);
- some e2w_wrpipeM=1;
- e2w_destpipeM equals the source index.
REQ-009 When several pipes M match, pipe 3 SHALL win over pipe 2, and pipe 2 over pipe 1.
REQ-010 A forwarded operand SHALL be re-masked as the register-file stage would mask it: low 32 bits for mul, low 4 bits of src2 for shifts 1100-1111.
REQ-011 e2w_destpipeN SHALL register d2e_destpipeN whenever flush=0.
REQ-012 flush=1 at a rising edge SHALL load all e2w_* outputs with 0.
REQ-013 Because of REQ-012, no forwarding SHALL occur in the cycle following a flush.
REQ-014 Pipes SHALL be independent in the same cycle; there is no intra-bundle forwarding, so a pipe reading a register written by another pipe of the same bundle SHALL get r2e data.
REQ-015 Same-cycle writes to the same dest from several pipes SHALL all be presented at the outputs unchanged; resolution is the writeback stage's responsibility.

Reset
REQ-016 While reset=0, all e2w_* outputs SHALL be 0 immediately, independent of clock.
REQ-017 With all outputs at 0, forwarding SHALL be inactive after reset.
REQ-018 Deasserting reset SHALL take effect at the next rising edge, and the first instruction presented SHALL see no forwarded data.
REQ-019 Reset asserted mid-stream SHALL discard all in-flight results.

Verification
REQ-020 Add with forward: pipe1 add dest=3, A=5, B=7, then next cycle pipe2 add src1=3, r2e_src1data=0, B=1 -> cycle 1: e2w_datapipe1=12, wr=1, dest=3; cycle 2: e2w_datapipe2=13.
REQ-021 Priority: pipe1 and pipe3 both write dest=4 with 10 and 30; next cycle pipe1 move src1=4 -> e2w_datapipe1=30.
REQ-022 Mul and rotate:
- mul A=0x1_00000002, B=3 -> 6.
- rotate right A=0x1, B=0x21 -> 0x8000000000000000 (amount 1).
- shift left A=1, B=0 -> 1.
REQ-023 Flush: flush=1 with pipe1 add dest=2 -> all outputs 0 next cycle; the following instruction reading src=2 uses r2e data.
REQ-024 Compare and read:
- compare 5,5 -> 1; compare 9,4 -> 2; compare 4,9 -> 0.
- read A=0xABC -> data 0xABC, wr=0, rdvalid=1.
REQ-025 Async reset: assert reset=0 between clock edges with nonzero outputs -> outputs 0 without a clock edge; after release, a src matching an old dest gets r2e data.
